// File: rtl/ps2_key_arbiter.sv
// ps2_key_arbiter: merges PS/2 keyboard events with timed press/hold/release/gap auto-typer injection
// Optional KEY_ABORT_EN: a keyboard press during injection flushes the queue and pulses inj_abort.
module ps2_key_arbiter #(
  parameter int FIFO_AW = 2,
  parameter int HOLD_CYCLES = 520000,
  parameter int GAP_CYCLES = 520000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] kbd_key,
  input  logic        inj_valid,
  input  logic [8:0]  inj_code,
  output logic        inj_ready,
  output logic [10:0] out_key,
  output logic        inj_active,
  output logic        inj_abort
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, GAP} state_t;
  state_t state, state_nx;
  logic [8:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [8:0] cur, cur_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic kbd_tog, kbd_evt, fifo_empty, fifo_full, wr_en, rd_en, abort, emit_inj, inj_press;
  assign kbd_evt = kbd_key[10] != kbd_tog;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full = wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW] && wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0];
  assign inj_ready = reset_n & ~fifo_full;
  assign inj_active = state != IDLE || !fifo_empty;
  assign wr_en = inj_valid & inj_ready & ~abort;
`ifdef KEY_ABORT_EN
  assign abort = kbd_evt & kbd_key[9] & inj_active;
  always_ff @(posedge clk_sys) inj_abort <= reset_n & abort;
`else
  assign abort = 1'b0;
  assign inj_abort = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    cur_nx = cur;
    cnt_nx = cnt;
    rd_en = 1'b0;
    emit_inj = 1'b0;
    inj_press = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !abort) begin
        rd_en = 1'b1;
        cur_nx = mem[rd_ptr[FIFO_AW-1:0]];
        state_nx = PRESS;
      end
      PRESS: if (abort) state_nx = IDLE;
        else if (!kbd_evt) begin
          emit_inj = 1'b1;
          inj_press = 1'b1;
          cnt_nx = CW'(HOLD_CYCLES - 1);
          state_nx = HOLD;
        end
      // an abort still lets the held key go up so the ZX81 never sees a stuck key
      HOLD: if (abort || cnt == '0) state_nx = RELEASE;
        else cnt_nx = cnt - 1'b1;
      RELEASE: if (!kbd_evt) begin
        emit_inj = 1'b1;
        cnt_nx = CW'(GAP_CYCLES - 1);
        state_nx = GAP;
      end
      GAP: if (abort || cnt == '0) state_nx = IDLE;
        else cnt_nx = cnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= inj_code;
  always_ff @(posedge clk_sys) begin
    kbd_tog <= kbd_key[10];
    if (!reset_n) begin
      state <= IDLE;
      cur <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_key <= '0;
    end else begin
      state <= state_nx;
      cur <= cur_nx;
      cnt <= cnt_nx;
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= abort ? wr_ptr : rd_en ? rd_ptr + 1'b1 : rd_ptr;
      out_key <= kbd_evt ? {~out_key[10], kbd_key[9:0]} : emit_inj ? {~out_key[10], inj_press, cur} : out_key;
    end
  end
endmodule

// File: tb/tb_ps2_key_arbiter.sv
// tb_ps2_key_arbiter: directed checks of keyboard pass-through, injection timing, FIFO, contention, reset
module tb_ps2_key_arbiter;
  logic clk_sys = 1'b0, reset_n = 1'b0, inj_valid = 1'b0;
  logic [10:0] kbd_key = '0;
  logic [8:0] inj_code = '0;
  logic inj_ready, inj_active, inj_abort;
  logic [10:0] out_key, prev;
  int checks = 0, errors = 0, idx = 0;
  logic [8:0] codes [5] = '{9'h01A, 9'h01B, 9'h121, 9'h023, 9'h024};
  logic [10:0] seq [10] = '{11'h61A, 11'h01A, 11'h61B, 11'h01B, 11'h721,
                            11'h121, 11'h623, 11'h023, 11'h624, 11'h024};
  ps2_key_arbiter #(.FIFO_AW(2), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kbd_key(kbd_key), .inj_valid(inj_valid),
    .inj_code(inj_code), .inj_ready(inj_ready), .out_key(out_key),
    .inj_active(inj_active), .inj_abort(inj_abort)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mon_tick();
    tick();
    if (out_key !== prev) begin
      if (idx < 10) check("c_seq", out_key, seq[idx]);
      idx++;
      prev = out_key;
    end
  endtask
  initial begin
    tick(2);
    check("rst_ready_low", {10'b0, inj_ready}, 11'd0);
    check("rst_out", out_key, 11'h000);
    reset_n = 1'b1;
    #1;
    check("rst_ready", {10'b0, inj_ready}, 11'd1);
    check("rst_active", {10'b0, inj_active}, 11'd0);
    check("rst_abort", {10'b0, inj_abort}, 11'd0);
    kbd_key = 11'h61C;
    tick();
    check("kbd_press", out_key, 11'h61C);
    tick();
    check("kbd_hold_no_evt", out_key, 11'h61C);
    kbd_key = 11'h01C;
    tick();
    check("kbd_release", out_key, 11'h01C);
    inj_valid = 1'b1;
    inj_code = 9'h016;
    tick();
    inj_valid = 1'b0;
    check("b_active", {10'b0, inj_active}, 11'd1);
    tick();
    check("b_e1", out_key, 11'h01C);
    tick();
    check("b_press", out_key, 11'h616);
    tick(4);
    check("b_e6", out_key, 11'h616);
    tick();
    check("b_release", out_key, 11'h016);
    tick(2);
    check("b_active_e9", {10'b0, inj_active}, 11'd1);
    tick(2);
    check("b_idle_e11", {10'b0, inj_active}, 11'd0);
    prev = out_key;
    for (int i = 0; i < 5; i++) begin
      inj_valid = 1'b1;
      inj_code = codes[i];
      check("c_ready", {10'b0, inj_ready}, 11'd1);
      mon_tick();
    end
    inj_valid = 1'b0;
    check("c_full", {10'b0, inj_ready}, 11'd0);
    for (int c = 0; c < 80; c++) mon_tick();
    check("c_count", 11'(idx), 11'd10);
    check("c_idle", {10'b0, inj_active}, 11'd0);
    inj_valid = 1'b1;
    inj_code = 9'h033;
    tick();
    inj_valid = 1'b0;
    tick();
    kbd_key = 11'h64C;
    tick();
    check("d_kbd_first", out_key, 11'h64C);
    tick();
    check("d_inj_press", out_key, 11'h233);
    tick(4);
    check("d_hold", out_key, 11'h233);
    tick();
    check("d_release", out_key, 11'h433);
    tick(6);
    check("d_idle", {10'b0, inj_active}, 11'd0);
    kbd_key = 11'h04C;
    tick();
    check("d_kbd_release", out_key, 11'h04C);
    inj_valid = 1'b1;
    inj_code = 9'h03A;
    tick();
    inj_valid = 1'b0;
    tick(2);
    check("f_press", out_key, 11'h63A);
    tick();
    reset_n = 1'b0;
    tick();
    check("f_rst_out", out_key, 11'h000);
    check("f_rst_active", {10'b0, inj_active}, 11'd0);
    check("f_rst_ready", {10'b0, inj_ready}, 11'd0);
    reset_n = 1'b1;
    tick(12);
    check("f_no_release", out_key, 11'h000);
    check("f_ready", {10'b0, inj_ready}, 11'd1);
`ifdef KEY_ABORT_EN
    for (int i = 0; i < 3; i++) begin
      inj_valid = 1'b1;
      inj_code = 9'h015 + 9'(i);
      tick();
    end
    inj_valid = 1'b0;
    check("e_press", out_key, 11'h615);
    tick();
    kbd_key = 11'h629;
    tick();
    check("e_kbd", out_key, 11'h229);
    check("e_abort", {10'b0, inj_abort}, 11'd1);
    check("e_flushed", {10'b0, inj_ready}, 11'd1);
    tick();
    check("e_release", out_key, 11'h415);
    check("e_abort_pulse", {10'b0, inj_abort}, 11'd0);
    tick(2);
    check("e_gap_active", {10'b0, inj_active}, 11'd1);
    tick();
    check("e_idle", {10'b0, inj_active}, 11'd0);
    tick(10);
    check("e_no_more", out_key, 11'h415);
    kbd_key = 11'h029;
    tick();
    check("e_kbd_release", out_key, 11'h029);
`else
    check("abort_tied", {10'b0, inj_abort}, 11'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
